maze_game_ctrl: RTL

- Game controller that sequences the maze renderer.
- Owns the display mode (welcome / map / win) and the player's current block position.
- Turns debounced direction pulses into wall-checked moves against the shared maze map.
- Commits position changes only at frame start, so a frame never shows a half-updated position. Sits between the keypad/debounce logic and the renderer.

---
 rtl/maze_pkg.sv | 32 +++
 rtl/maze_game_ctrl_if.sv | 34 +++
 rtl/maze_move_check.sv | 65 ++++++
 rtl/maze_game_ctrl.sv | 113 +++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared maze definitions: display mode encodings, controller states, map geometry.
// Also used by the renderer. Optional step counter is gated by MAZE_STEP_CNT_EN in the controller files.
package maze_pkg;

  localparam logic [1:0] MODE_MAP     = 2'b00;
  localparam logic [1:0] MODE_WELCOME = 2'b01;
  localparam logic [1:0] MODE_WIN     = 2'b10;

  localparam int unsigned MAZE_NUM_MAX = 19;
  localparam int unsigned MAP_BITS     = MAZE_NUM_MAX * MAZE_NUM_MAX;
  localparam int unsigned IDX_BITS     = 9;
  localparam int unsigned NUM_W        = 5;
  localparam int unsigned STEP_W       = 10;

  typedef enum logic [2:0] {
    ST_WELCOME,
    ST_PLAY,
    ST_IDX,
    ST_TEST,
    ST_COMMIT,
    ST_WIN
  } state_t;

  function automatic logic [NUM_W-1:0] clamp_num(input logic [NUM_W-1:0] v,
                                                 input int unsigned lo,
                                                 input int unsigned hi);
    if (32'(v) < lo) return NUM_W'(lo);
    if (32'(v) > hi) return NUM_W'(hi);
    return v;
  endfunction

endpackage

// File: rtl/maze_game_ctrl_if.sv
// Keypad/renderer-facing bundle of the maze game controller.
// step_cnt exists only when MAZE_STEP_CNT_EN is defined.
interface maze_game_ctrl_if #(
  parameter int unsigned IDX_W = 9
);
  import maze_pkg::*;

  logic                  start;
  logic                  key_up;
  logic                  key_down;
  logic                  key_left;
  logic                  key_right;
  logic                  frame_start;
  logic [NUM_W-1:0]      num;
  logic [MAP_BITS-1:0]   map;
  logic [1:0]            mode;
  logic [IDX_W-1:0]      cur_x;
  logic [IDX_W-1:0]      cur_y;
  logic                  busy;
  logic                  bump;
`ifdef MAZE_STEP_CNT_EN
  logic [STEP_W-1:0]     step_cnt;

  modport master (output start, key_up, key_down, key_left, key_right, frame_start, num, map,
                  input  mode, cur_x, cur_y, busy, bump, step_cnt);
  modport slave  (input  start, key_up, key_down, key_left, key_right, frame_start, num, map,
                  output mode, cur_x, cur_y, busy, bump, step_cnt);
`else
  modport master (output start, key_up, key_down, key_left, key_right, frame_start, num, map,
                  input  mode, cur_x, cur_y, busy, bump);
  modport slave  (input  start, key_up, key_down, key_left, key_right, frame_start, num, map,
                  output mode, cur_x, cur_y, busy, bump);
`endif
endinterface

// File: rtl/maze_move_check.sv
// Move validation: key priority encode, border range check, map index register, wall lookup.
// bump is the registered reject pulse (range reject or wall hit).
module maze_move_check import maze_pkg::*; #(
  parameter int unsigned IDX_W = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key_en,
  input  logic                key_up,
  input  logic                key_down,
  input  logic                key_left,
  input  logic                key_right,
  input  logic                idx_en,
  input  logic                test_en,
  input  logic [IDX_W-1:0]    cur_x,
  input  logic [IDX_W-1:0]    cur_y,
  input  logic [NUM_W-1:0]    n_l,
  input  logic [MAP_BITS-1:0] map,
  output logic                accept,
  output logic                wall,
  output logic [IDX_W-1:0]    tx,
  output logic [IDX_W-1:0]    ty,
  output logic                bump
);

  logic                hit;
  logic                in_range;
  logic [IDX_W-1:0]    nx;
  logic [IDX_W-1:0]    ny;
  logic [IDX_W-1:0]    lim;
  logic [IDX_BITS-1:0] idx;

  always_comb begin
    hit = key_up | key_down | key_left | key_right;
    nx  = cur_x;
    ny  = cur_y;
    if (key_up)         ny = cur_y - IDX_W'(1);
    else if (key_down)  ny = cur_y + IDX_W'(1);
    else if (key_left)  nx = cur_x - IDX_W'(1);
    else if (key_right) nx = cur_x + IDX_W'(1);
  end

  // A decrement from 0 wraps to all-ones, which the upper bound rejects.
  assign lim      = IDX_W'(n_l) - IDX_W'(1);
  assign in_range = (nx != '0) && (ny != '0) && (nx < lim) && (ny < lim);
  assign accept   = key_en & hit & in_range;
  assign wall     = (32'(idx) < MAP_BITS) ? map[idx] : 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx   <= '0;
      ty   <= '0;
      idx  <= '0;
      bump <= 1'b0;
    end else begin
      bump <= (key_en & hit & ~in_range) | (test_en & wall);
      if (key_en && hit) begin
        tx <= nx;
        ty <= ny;
      end
      if (idx_en) idx <= IDX_BITS'(tx) * IDX_BITS'(n_l) + IDX_BITS'(ty);
    end
  end

endmodule

// File: rtl/maze_game_ctrl.sv
// Maze game controller: display mode, player position, wall-checked moves committed at frame start.
// Define MAZE_STEP_CNT_EN to add the saturating committed-move counter step_cnt.
module maze_game_ctrl import maze_pkg::*; #(
  parameter int unsigned IDX_W     = 9,
  parameter int unsigned NUM_MIN   = 5,
  parameter int unsigned NUM_MAX   = 19,
  parameter int unsigned START_IDX = 1
) (
  input  logic             clk,
  input  logic             rst,
  maze_game_ctrl_if.slave  bus
);

  state_t           state;
  state_t           state_nx;
  logic [1:0]       mode_d;
  logic [NUM_W-1:0] n_l;
  logic [IDX_W-1:0] tx;
  logic [IDX_W-1:0] ty;
  logic             accept;
  logic             wall;
  logic             key_en;
  logic             test_en;
  logic             commit;
  logic             win_hit;

  assign key_en  = (state == ST_PLAY) && !bus.start;
  assign test_en = (state == ST_TEST) && !bus.start;
  assign commit  = (state == ST_COMMIT) && bus.frame_start && !bus.start;
  assign win_hit = (tx == IDX_W'(n_l) - IDX_W'(2)) && (ty == IDX_W'(n_l) - IDX_W'(2));

  maze_move_check #(.IDX_W(IDX_W)) u_check (
    .clk       (clk),
    .rst       (rst),
    .key_en    (key_en),
    .key_up    (bus.key_up),
    .key_down  (bus.key_down),
    .key_left  (bus.key_left),
    .key_right (bus.key_right),
    .idx_en    (state == ST_IDX),
    .test_en   (test_en),
    .cur_x     (bus.cur_x),
    .cur_y     (bus.cur_y),
    .n_l       (n_l),
    .map       (bus.map),
    .accept    (accept),
    .wall      (wall),
    .tx        (tx),
    .ty        (ty),
    .bump      (bus.bump)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_WELCOME;
      bus.mode <= MODE_WELCOME;
    end else begin
      state    <= state_nx;
      bus.mode <= mode_d;
    end
  end

  // start restarts the game from any state and outranks keys and frame_start.
  always_comb begin
    state_nx = state;
    if (bus.start) begin
      state_nx = ST_PLAY;
    end else begin
      case (state)
        ST_PLAY:   if (accept) state_nx = ST_IDX;
        ST_IDX:    state_nx = ST_TEST;
        ST_TEST:   state_nx = wall ? ST_PLAY : ST_COMMIT;
        ST_COMMIT: if (bus.frame_start) state_nx = win_hit ? ST_WIN : ST_PLAY;
        default:   state_nx = state;
      endcase
    end
  end

  // mode is decoded from the next state so the registered output tracks state exactly.
  always_comb begin
    mode_d = MODE_MAP;
    case (state_nx)
      ST_WELCOME: mode_d = MODE_WELCOME;
      ST_WIN:     mode_d = MODE_WIN;
      default:    mode_d = MODE_MAP;
    endcase
    bus.busy = (state == ST_IDX) || (state == ST_TEST) || (state == ST_COMMIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.cur_x <= IDX_W'(START_IDX);
      bus.cur_y <= IDX_W'(START_IDX);
      n_l       <= '0;
    end else if (bus.start) begin
      bus.cur_x <= IDX_W'(START_IDX);
      bus.cur_y <= IDX_W'(START_IDX);
      n_l       <= clamp_num(bus.num, NUM_MIN, NUM_MAX);
    end else if (commit) begin
      bus.cur_x <= tx;
      bus.cur_y <= ty;
    end
  end

`ifdef MAZE_STEP_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            bus.step_cnt <= '0;
    else if (bus.start)                 bus.step_cnt <= '0;
    else if (commit && bus.step_cnt != '1) bus.step_cnt <= bus.step_cnt + STEP_W'(1);
  end
`endif

endmodule
